// File: rtl/mvm_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : mvm_pkg                                                      |
// | Description : Widths, FSM state type and clamp helper for da_mvm_serial.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package mvm_pkg;

  // Width helpers let every instance derive its own widths from N and S.
  function automatic int bs_width(input int n, input int s);
    return n + $clog2(s);
  endfunction

  function automatic int acc_width(input int n, input int s);
    return 2 * n + $clog2(s);
  endfunction

  localparam int BS_W  = bs_width(8, 8);
  localparam int ACC_W = acc_width(8, 8);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Clamps to 2^out_w-1; accumulators are carried zero-extended to 64 bits.
  function automatic logic [63:0] sat_clamp(input logic [63:0] acc, input int out_w);
    if (out_w >= 64) return acc;
    if ((acc >> out_w) != 64'd0) return (64'd1 << out_w) - 64'd1;
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/da_row_engine.sv
// +----------------------------------------------------------------------------+
// | Module      : da_row_engine                                                |
// | Description : One matrix row: pair LUTs, bit-plane adder tree, accumulator.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module da_row_engine
  import mvm_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          enable,
  input  logic [$clog2(N)-1:0]          bit_idx,
  input  logic [S*N-1:0]                u_vec,
  input  logic [S-1:0]                  w_bits,
  output logic [acc_width(N, S)-1:0]    acc_nxt
);

  localparam int c_bs_w  = bs_width(N, S);
  localparam int c_acc_w = acc_width(N, S);

  logic [c_acc_w-1:0] r_acc;
  logic [c_bs_w-1:0]  w_bit_sum;
  logic [N:0]         w_pair;

  always_comb begin
    w_bit_sum = '0;
    w_pair    = '0;
    for (int p = 0; p < S / 2; p++) begin
      case ({w_bits[2*p+1], w_bits[2*p]})
        2'b01:   w_pair = {1'b0, u_vec[2*p*N +: N]};
        2'b10:   w_pair = {1'b0, u_vec[(2*p+1)*N +: N]};
        2'b11:   w_pair = {1'b0, u_vec[2*p*N +: N]} + {1'b0, u_vec[(2*p+1)*N +: N]};
        default: w_pair = '0;
      endcase
      w_bit_sum = w_bit_sum + c_bs_w'(w_pair);
    end
  end

  assign acc_nxt = r_acc + (c_acc_w'(w_bit_sum) << bit_idx);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (enable) begin
      r_acc <= acc_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/da_mvm_serial.sv
// +----------------------------------------------------------------------------+
// | Module      : da_mvm_serial                                                |
// | Description : Bit-serial distributed-arithmetic R x S matrix-vector mult.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module da_mvm_serial
  import mvm_pkg::*;
#(
  parameter int N     = 8,
  parameter int S     = 8,
  parameter int R     = 4,
  parameter int OUT_W = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [S*N-1:0]       u,
  input  logic [R*S*N-1:0]     w,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [R*OUT_W-1:0]   v,
  output logic [R-1:0]         sat
);

  localparam int c_acc_w = acc_width(N, S);
  localparam int c_cnt_w = $clog2(N);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_b;
  logic [S*N-1:0]       r_u;
  logic [R*S*N-1:0]     r_w;
  logic [R*OUT_W-1:0]   r_v;
  logic [R-1:0]         r_sat;
  logic [R*OUT_W-1:0]   w_v_nxt;
  logic [R-1:0]         w_sat_nxt;
  logic                 w_accept;
  logic                 w_compute;
  logic                 w_last;

  assign w_compute = (r_state == COMPUTE);
  assign w_last    = w_compute && (r_b == c_cnt_w'(N - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = COMPUTE;
        end
      end
      COMPUTE: if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_b     <= '0;
      r_u     <= '0;
      r_w     <= '0;
      r_v     <= '0;
      r_sat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_u <= u;
        r_w <= w;
        r_b <= '0;
      end else if (w_last) begin
        r_b <= '0;
      end else if (w_compute) begin
        r_b <= r_b + 1'b1;
      end
      // Results take the accumulator value including this cycle's final bit-plane.
      if (w_last) begin
        r_v   <= w_v_nxt;
        r_sat <= w_sat_nxt;
      end
    end
  end

  for (genvar r = 0; r < R; r++) begin : g_row
    logic [S-1:0]       w_plane;
    logic [c_acc_w-1:0] w_acc_nxt;

    always_comb begin
      w_plane = '0;
      for (int j = 0; j < S; j++) begin
        w_plane[j] = r_w[(r*S+j)*N + int'(r_b)];
      end
    end

    da_row_engine #(.N(N), .S(S)) u_engine (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .clear    (w_accept),
      .enable   (w_compute),
      .bit_idx  (r_b),
      .u_vec    (r_u),
      .w_bits   (w_plane),
      .acc_nxt  (w_acc_nxt)
    );

    assign w_v_nxt[r*OUT_W +: OUT_W] = OUT_W'(sat_clamp(64'(w_acc_nxt), OUT_W));

    if (OUT_W >= c_acc_w) begin : g_nosat
      assign w_sat_nxt[r] = 1'b0;
    end else begin : g_sat
      assign w_sat_nxt[r] = |w_acc_nxt[c_acc_w-1:OUT_W];
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign v         = r_v;
  assign sat       = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_da_mvm_serial.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_da_mvm_serial                                             |
// | Description : Self-checking bench for da_mvm_serial against a dot model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_da_mvm_serial;

  localparam int N     = 8;
  localparam int S     = 8;
  localparam int R     = 4;
  localparam int OUT_W = 8;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset_n  = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic [S*N-1:0]       u = '0;
  logic [R*S*N-1:0]     w = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [R*OUT_W-1:0]   v;
  logic [R-1:0]         sat;

  int checks = 0;
  int errors = 0;

  da_mvm_serial #(.N(N), .S(S), .R(R), .OUT_W(OUT_W)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .v         (v),
    .sat       (sat)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("FAIL %s", tag);
    end
  endtask

  // Reference: plain dot products, then clamp at 2^OUT_W-1.
  function automatic void model(input logic [S*N-1:0] uf, input logic [R*S*N-1:0] wf,
                                output logic [R*OUT_W-1:0] ev, output logic [R-1:0] es);
    longint unsigned acc;
    longint unsigned maxv;
    maxv = (64'd1 << OUT_W) - 1;
    ev = '0;
    es = '0;
    for (int r = 0; r < R; r++) begin
      acc = 0;
      for (int j = 0; j < S; j++)
        acc += longint'(uf[j*N +: N]) * longint'(wf[(r*S+j)*N +: N]);
      if (acc > maxv) begin
        ev[r*OUT_W +: OUT_W] = OUT_W'(maxv);
        es[r] = 1'b1;
      end else begin
        ev[r*OUT_W +: OUT_W] = OUT_W'(acc);
      end
    end
  endfunction

  task automatic scramble_inputs();
    u = {$urandom, $urandom};
    for (int i = 0; i < R*S*N/32; i++) w[i*32 +: 32] = $urandom;
  endtask

  task automatic send(input string tag, input logic [S*N-1:0] uf,
                      input logic [R*S*N-1:0] wf, input int hold);
    logic [R*OUT_W-1:0] ev;
    logic [R-1:0]       es;
    int k;
    model(uf, wf, ev, es);
    u = uf;
    w = wf;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge CLOCK_50); #1;
      k++;
    end
    check({tag, " ready"}, 64'(in_ready), 64'd1);
    @(posedge CLOCK_50); #1;
    in_valid = 1'b0;
    scramble_inputs();
    check({tag, " busy"}, 64'(in_ready), 64'd0);
    k = 0;
    while (!out_valid && k < N + 8) begin
      @(posedge CLOCK_50); #1;
      k++;
      if (k < N) scramble_inputs();
    end
    check({tag, " latency"}, 64'(k), 64'(N));
    check({tag, " v"}, 64'(v), 64'(ev));
    check({tag, " sat"}, 64'(sat), 64'(es));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(posedge CLOCK_50); #1;
      check({tag, " hold v"}, 64'(v), 64'(ev));
      check({tag, " hold sat"}, 64'(sat), 64'(es));
      check({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    out_ready = 1'b0;
    check({tag, " release valid"}, 64'(out_valid), 64'd0);
    check({tag, " release ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [S*N-1:0]   uf;
    logic [R*S*N-1:0] wf;

    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset v", 64'(v), 64'd0);
    check("reset sat", 64'(sat), 64'd0);
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;

    // All ones: each row sums eight 1*1 products.
    for (int j = 0; j < S; j++) uf[j*N +: N] = N'(1);
    for (int k = 0; k < R*S; k++) wf[k*N +: N] = N'(1);
    send("ones", uf, wf, 0);

    // Identity rows select u[r].
    wf = '0;
    for (int j = 0; j < S; j++) uf[j*N +: N] = N'(10 * (j + 1));
    for (int r = 0; r < R; r++) wf[(r*S+r)*N +: N] = N'(1);
    send("identity", uf, wf, 0);

    // Full-scale operands saturate every row.
    uf = '1;
    wf = '1;
    send("saturate", uf, wf, 0);

    // Row 0 exercises the "11" pair case and clamps; other rows stay in range.
    uf = '0;
    wf = '0;
    uf[0 +: N] = N'(100);
    uf[N +: N] = N'(120);
    for (int r = 0; r < R; r++) begin
      wf[(r*S)*N +: N]   = (r == 0) ? N'(3) : N'(1);
      wf[(r*S+1)*N +: N] = (r == 0) ? N'(3) : N'(1);
    end
    send("pair11", uf, wf, 0);

    // Back-pressure with a competing request, then the next vector goes through.
    for (int j = 0; j < S; j++) uf[j*N +: N] = N'($urandom_range(0, 31));
    for (int k = 0; k < R*S; k++) wf[k*N +: N] = N'($urandom_range(0, 3));
    send("handshake1", uf, wf, 5);
    for (int j = 0; j < S; j++) uf[j*N +: N] = N'($urandom_range(0, 15));
    for (int k = 0; k < R*S; k++) wf[k*N +: N] = N'($urandom_range(0, 3));
    send("handshake2", uf, wf, 0);

    // Asynchronous reset while b == 3.
    u = {$urandom, $urandom};
    for (int i = 0; i < R*S*N/32; i++) w[i*32 +: 32] = $urandom;
    in_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    in_valid = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset v", 64'(v), 64'd0);
    check("midreset sat", 64'(sat), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;
    check("postreset out_valid", 64'(out_valid), 64'd0);
    for (int j = 0; j < S; j++) uf[j*N +: N] = N'($urandom_range(0, 20));
    for (int k = 0; k < R*S; k++) wf[k*N +: N] = N'($urandom_range(0, 2));
    send("after_reset", uf, wf, 0);

    // Random vectors alternating small (mostly in range) and full-range operands.
    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < S; j++)
        uf[j*N +: N] = (t % 2 == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
      for (int k = 0; k < R*S; k++)
        wf[k*N +: N] = (t % 2 == 0) ? N'($urandom_range(0, 3)) : N'($urandom);
      send($sformatf("random%0d", t), uf, wf, t % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
